// File: rtl/cpu_consts.sv
// Shared core constants and types for the instruction fetch path.
package cpu_consts;

  localparam int XLEN    = 64;
  localparam int INSTR_W = 32;

  typedef logic [XLEN-1:0]    addr_t;
  typedef logic [INSTR_W-1:0] instr_t;

  localparam instr_t NOP_INSTR = 32'h0000_0013;

  // Sequential instruction address; wraps modulo 2^XLEN.
  function automatic addr_t next_pc(input addr_t pc);
    return pc + addr_t'(4);
  endfunction

endpackage

// File: rtl/ipf_fifo.sv
// Circular instruction buffer, DEPTH x 32, with combinational head read and flush.
module ipf_fifo
  import cpu_consts::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  instr_t                 wdata_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output instr_t                 rdata_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);

  instr_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Power-of-two depth: pointers wrap at DEPTH by natural overflow.
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push_i, pop_i})
        2'b10:   count_d = count_q + (PW+1)'(1);
        2'b01:   count_d = count_q - (PW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_prefetch.sv
// Sequential instruction prefetch queue with redirect flush and in-flight drop.
// Define IPF_BYPASS_EN to forward a response straight to the core when the queue is empty.
module instr_prefetch
  import cpu_consts::*;
#(
  parameter logic [63:0] RESET_PC        = 64'h0000_0000,
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cpu_req_i,
  input  logic [XLEN-1:0]    cpu_addr_i,
  output logic [INSTR_W-1:0] cpu_instr_o,
  output logic               cpu_instr_valid_o,
  output logic               mem_req_o,
  output logic [XLEN-1:0]    mem_addr_o,
  input  logic               mem_gnt_i,
  input  logic               mem_rvalid_i,
  input  logic [INSTR_W-1:0] mem_rdata_i
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  addr_t         head_addr_q, head_addr_d;
  addr_t         fetch_addr_q, fetch_addr_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [OW-1:0] drop_q, drop_d;

  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  instr_t        head_instr;
  logic          addr_match, hit, redirect, bypass;
  logic          grant, resp, discard, push;

  // Responses with nothing outstanding are spurious and ignored.
  assign resp       = mem_rvalid_i & (outst_q != '0);
  assign addr_match = (cpu_addr_i == head_addr_q);
  assign hit        = cpu_req_i & (count != '0) & addr_match;
  assign redirect   = cpu_req_i & ~addr_match;

`ifdef IPF_BYPASS_EN
  assign bypass = cpu_req_i & addr_match & (count == '0) & (drop_q == '0) & resp;
`else
  assign bypass = 1'b0;
`endif

  // Queue slots plus in-flight requests never exceed DEPTH, so a push never meets a full queue.
  assign occupancy = (CW+1)'(count) + (CW+1)'(outst_q);
  assign mem_req_o = (occupancy < (CW+1)'(DEPTH)) & (outst_q < OW'(MAX_OUTSTANDING));
  assign mem_addr_o = fetch_addr_q;

  assign grant   = mem_req_o & mem_gnt_i;
  assign discard = resp & (drop_q != '0);
  assign push    = resp & ~discard & ~bypass & ~redirect;

  always_comb begin
    outst_d      = outst_q + OW'(grant) - OW'(resp);
    drop_d       = drop_q;
    head_addr_d  = head_addr_q;
    fetch_addr_d = fetch_addr_q;
    if (redirect) begin
      // Everything still in flight after this edge belongs to the old stream.
      drop_d       = outst_d;
      head_addr_d  = cpu_addr_i;
      fetch_addr_d = cpu_addr_i;
    end else begin
      if (discard)      drop_d       = drop_q - OW'(1);
      if (hit | bypass) head_addr_d  = next_pc(head_addr_q);
      if (grant)        fetch_addr_d = next_pc(fetch_addr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_addr_q  <= RESET_PC;
      fetch_addr_q <= RESET_PC;
      outst_q      <= '0;
      drop_q       <= '0;
    end else begin
      head_addr_q  <= head_addr_d;
      fetch_addr_q <= fetch_addr_d;
      outst_q      <= outst_d;
      drop_q       <= drop_d;
    end
  end

  always_comb begin
    cpu_instr_valid_o = hit | bypass;
    cpu_instr_o       = NOP_INSTR;
    if (bypass)   cpu_instr_o = mem_rdata_i;
    else if (hit) cpu_instr_o = head_instr;
  end

  ipf_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (push),
    .wdata_i(mem_rdata_i),
    .pop_i  (hit),
    .flush_i(redirect),
    .rdata_o(head_instr),
    .count_o(count)
  );

endmodule

// File: tb/tb_instr_prefetch.sv
// Scoreboard bench for instr_prefetch: in-order memory model with random grant/latency.
module tb_instr_prefetch;
  import cpu_consts::*;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               cpu_req = 1'b0;
  logic [XLEN-1:0]    cpu_addr = '0;
  logic [INSTR_W-1:0] cpu_instr;
  logic               cpu_instr_valid;
  logic               mem_req;
  logic [XLEN-1:0]    mem_addr;
  logic               mem_gnt;
  logic               mem_rvalid;
  logic [INSTR_W-1:0] mem_rdata;

  int total = 0;
  int bad = 0;

`ifdef IPF_BYPASS_EN
  localparam int MISS_LAT = 1;
`else
  localparam int MISS_LAT = 2;
`endif

  logic [63:0] pend_addr[$];
  int          pend_due[$];
  logic [63:0] exp_addr[$];
  logic [31:0] exp_data[$];
  int cyc = 0;
  int gnt_pct = 100;
  int dly_lo = 0;
  int dly_hi = 0;
  int grant_cnt = 0;

  always #5 clk = ~clk;

  instr_prefetch #(
    .RESET_PC(64'h0),
    .DEPTH(4),
    .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cpu_req_i(cpu_req),
    .cpu_addr_i(cpu_addr),
    .cpu_instr_o(cpu_instr),
    .cpu_instr_valid_o(cpu_instr_valid),
    .mem_req_o(mem_req),
    .mem_addr_o(mem_addr),
    .mem_gnt_i(mem_gnt),
    .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata)
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0013;
  endfunction

  // Memory: decides grant/response for the coming edge, 1 time unit after each negedge.
  initial begin
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (reset) begin
        pend_addr.delete();
        pend_due.delete();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata = $urandom;
        if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
          mem_rvalid = 1'b1;
          mem_rdata = mem_word(pend_addr.pop_front());
          void'(pend_due.pop_front());
        end
        mem_gnt = (int'($urandom_range(99, 0)) < gnt_pct);
        if (mem_gnt && mem_req) begin
          pend_addr.push_back(mem_addr);
          pend_due.push_back(cyc + 1 + int'($urandom_range(dly_hi, dly_lo)));
          grant_cnt++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time expired, required finish before 1000000");
    $fatal(1, "watchdog");
  end

  // Must be entered at a negedge; leaves reset low at a negedge (cycle 0).
  task automatic do_reset();
    reset = 1'b1;
    cpu_req = 1'b0;
    exp_addr.delete();
    exp_data.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    grant_cnt = 0;
  endtask

  // One core cycle: drive request, pop the scoreboard when an instruction is delivered.
  task automatic core_step(input logic req, input logic [63:0] addr, output logic got);
    logic [63:0] ea;
    logic [31:0] ed;
    cpu_req = req;
    cpu_addr = addr;
    if (req && (exp_addr.size() == 0 || exp_addr[0] != addr)) begin
      exp_addr.delete();
      exp_data.delete();
      exp_addr.push_back(addr);
      exp_data.push_back(mem_word(addr));
    end
    #3;
    got = cpu_instr_valid;
    total++;
    if (got) begin
      if (!req || exp_addr.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid: valid=1 instr=%h, required valid=0 (req=%0b)", cpu_instr, req);
      end else begin
        ea = exp_addr.pop_front();
        ed = exp_data.pop_front();
        if (cpu_instr !== ed) begin
          bad++;
          $display("FAIL instr_data: addr=%h instr=%h, required %h", ea, cpu_instr, ed);
        end else begin
          $display("txn addr=%h instr=%h", ea, cpu_instr);
        end
      end
    end else if (cpu_instr !== NOP_INSTR) begin
      bad++;
      $display("FAIL nop_when_invalid: instr=%h, required %h", cpu_instr, NOP_INSTR);
    end
    @(negedge clk);
  endtask

  task automatic run_until_valid(input logic [63:0] addr, input int budget, output int steps);
    logic got;
    got = 1'b0;
    steps = 0;
    while (!got && steps < budget) begin
      core_step(1'b1, addr, got);
      steps++;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL fetch_timeout: addr=%h not delivered in %0d cycles, required delivery", addr, budget);
    end
  endtask

  task automatic test_reset();
    do_reset();
    cpu_req = 1'b1;
    cpu_addr = 64'h0;
    #3;
    total++;
    if (mem_req !== 1'b1) begin bad++; $display("FAIL reset_mem_req: got %b, required 1", mem_req); end
    total++;
    if (mem_addr !== 64'h0) begin bad++; $display("FAIL reset_mem_addr: got %h, required 0", mem_addr); end
    total++;
    if (cpu_instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b, required 0", cpu_instr_valid); end
    total++;
    if (cpu_instr !== NOP_INSTR) begin bad++; $display("FAIL reset_instr: got %h, required %h", cpu_instr, NOP_INSTR); end
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [63:0] pc;
    logic got;
    int first, nvalid;
    gnt_pct = 100; dly_lo = 0; dly_hi = 0;
    do_reset();
    pc = 0; first = -1; nvalid = 0;
    for (int i = 0; i < 20; i++) begin
      core_step(1'b1, pc, got);
      if (got) begin
        if (first < 0) first = i;
        nvalid++;
        pc = pc + 4;
      end
    end
    total++;
    if (first != MISS_LAT) begin bad++; $display("FAIL basic_first_valid: cycle %0d, required %0d", first, MISS_LAT); end
    total++;
    if (nvalid != 20 - MISS_LAT) begin bad++; $display("FAIL basic_throughput: %0d valid, required %0d", nvalid, 20 - MISS_LAT); end
  endtask

  task automatic test_stall();
    logic [63:0] pc;
    logic got;
    int nvalid;
    gnt_pct = 100; dly_lo = 0; dly_hi = 0;
    do_reset();
    for (int i = 0; i < 10; i++) core_step(1'b0, 64'h0, got);
    #3;
    total++;
    if (grant_cnt != 4) begin bad++; $display("FAIL stall_grants: %0d grants, required 4", grant_cnt); end
    total++;
    if (mem_req !== 1'b0) begin bad++; $display("FAIL stall_mem_req: got %b, required 0", mem_req); end
    @(negedge clk);
    pc = 0; nvalid = 0;
    for (int i = 0; i < 4; i++) begin
      core_step(1'b1, pc, got);
      if (got) begin nvalid++; pc = pc + 4; end
    end
    total++;
    if (nvalid != 4) begin bad++; $display("FAIL stall_drain: %0d back-to-back, required 4", nvalid); end
  endtask

  task automatic test_redirect_outst();
    logic got;
    int steps, n;
    gnt_pct = 100; dly_lo = 3; dly_hi = 3;
    do_reset();
    n = 0;
    while (pend_addr.size() != 2 && n < 10) begin
      core_step(1'b1, 64'h0, got);
      n++;
    end
    total++;
    if (pend_addr.size() != 2) begin bad++; $display("FAIL redir_setup: %0d outstanding, required 2", pend_addr.size()); end
    run_until_valid(64'h100, 40, steps);
    total++;
    if (steps != 7 + MISS_LAT) begin bad++; $display("FAIL redir_latency: %0d cycles, required %0d", steps, 7 + MISS_LAT); end
    run_until_valid(64'h104, 40, steps);
    run_until_valid(64'h108, 40, steps);
  endtask

  task automatic test_redirect_same_cycle();
    logic [63:0] pc;
    logic got;
    int steps, nvalid, n;
    gnt_pct = 100; dly_lo = 0; dly_hi = 0;
    do_reset();
    pc = 0; nvalid = 0; n = 0;
    while (nvalid < 5 && n < 20) begin
      core_step(1'b1, pc, got);
      if (got) begin nvalid++; pc = pc + 4; end
      n++;
    end
    core_step(1'b1, 64'h200, got);
    total++;
    if (got !== 1'b0) begin bad++; $display("FAIL same_redirect_valid: got %b, required 0", got); end
    run_until_valid(64'h200, 20, steps);
    total++;
    if (steps != MISS_LAT + 1) begin bad++; $display("FAIL same_redirect_latency: %0d cycles, required %0d", steps, MISS_LAT + 1); end
    run_until_valid(64'h204, 20, steps);
    total++;
    if (steps != 1) begin bad++; $display("FAIL same_redirect_next: %0d cycles, required 1", steps); end
  endtask

  task automatic test_wrap();
    int steps;
    gnt_pct = 100; dly_lo = 0; dly_hi = 0;
    do_reset();
    run_until_valid(64'hFFFF_FFFF_FFFF_FFF8, 20, steps);
    run_until_valid(64'hFFFF_FFFF_FFFF_FFFC, 20, steps);
    run_until_valid(64'h0, 20, steps);
    total++;
    if (steps != 1) begin bad++; $display("FAIL wrap_stream: %0d cycles after wrap, required 1", steps); end
    run_until_valid(64'h4, 20, steps);
  endtask

  function automatic logic [63:0] rand_addr();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(3, 0))
      0, 1:    r[63:12] = '0;
      2:       r[63:8]  = '1;
      default: ;
    endcase
    r[1:0] = 2'b00;
    return r;
  endfunction

  task automatic test_random();
    logic [63:0] pc;
    logic got, req;
    int n, wait_cyc, cycles;
    gnt_pct = 60; dly_lo = 0; dly_hi = 5;
    do_reset();
    pc = 0; n = 0; wait_cyc = 0; cycles = 0;
    while (n < 1000 && cycles < 30000 && wait_cyc < 200) begin
      req = ($urandom_range(19, 0) != 0);
      core_step(req, pc, got);
      cycles++;
      if (got) begin
        n++;
        wait_cyc = 0;
        pc = ($urandom_range(9, 0) == 0) ? rand_addr() : pc + 4;
      end else begin
        wait_cyc++;
        if (req && $urandom_range(29, 0) == 0) pc = rand_addr();
      end
    end
    total++;
    if (n != 1000) begin bad++; $display("FAIL random_count: %0d delivered, required 1000", n); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_stall();
    test_redirect_outst();
    test_redirect_same_cycle();
    test_wrap();
    test_random();
    test_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
